wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_pkg.sv | 25 ++
 rtl/wb_fifo.sv | 61 ++++++
 rtl/wb_arbiter.sv | 121 ++++++++++++
 tb/tb_wb_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and default parameters for the writeback arbiter slice.
package wb_pkg;

  localparam int WB_XLEN_DEF         = 32;
  localparam int WB_DEPTH_DEF        = 2;
  localparam int WB_STARVE_LIMIT_DEF = 4;
  localparam int WB_RD_W             = 5;

  typedef struct packed {
    logic [WB_RD_W-1:0]     rd;
    logic [WB_XLEN_DEF-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_FIFO = 2'd2
  } wb_src_e;

  // A single-entry FIFO still needs a 1-bit pointer.
  function automatic int wb_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO for multi-cycle writeback results; pointers wrap modulo DEPTH.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int  DEPTH = WB_DEPTH_DEF,
  parameter type T     = wb_req_t
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output T                           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = wb_ptr_w(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: stale slots are never read while the count says empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results take the write slot, mul/div results queue in wb_fifo.
// Define WB_STARVE_GUARD_EN to add a counter that forces a FIFO drain after STARVE_LIMIT ALU wins.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN         = WB_XLEN_DEF,
  parameter int DEPTH        = WB_DEPTH_DEF,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [4:0]                 alu_rd,
  input  logic [XLEN-1:0]            alu_data,
  input  logic                       md_valid,
  output logic                       md_ready,
  input  logic [4:0]                 md_rd,
  input  logic [XLEN-1:0]            md_data,
  input  logic                       halted,
  output logic                       rd_we,
  output logic [4:0]                 rd_num,
  output logic [XLEN-1:0]            rd_data,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       drained
);

  // Same layout as wb_req_t, sized to this instance's XLEN.
  typedef struct packed {
    logic [WB_RD_W-1:0] rd;
    logic [XLEN-1:0]    data;
  } req_t;

  req_t    alu_req;
  req_t    md_req;
  req_t    fifo_head;
  req_t    win_req;
  wb_src_e win_src;
  logic    fifo_full;
  logic    fifo_empty;
  logic    fifo_pop;
  logic    force_drain;
  logic    alu_acc;
  logic    md_acc;
  logic    win_we;

  assign alu_req.rd   = alu_rd;
  assign alu_req.data = alu_data;
  assign md_req.rd    = md_rd;
  assign md_req.data  = md_data;

  assign alu_ready = !halted && !force_drain;
  assign md_ready  = !halted && !fifo_full;
  assign alu_acc   = alu_valid && alu_ready;
  assign md_acc    = md_valid && md_ready;

  // Pop decision uses pre-push emptiness, so a fresh push is never popped the same cycle.
  always_comb begin
    win_src = SRC_NONE;
    if (alu_acc)          win_src = SRC_ALU;
    else if (!fifo_empty) win_src = SRC_FIFO;
  end

  assign fifo_pop = (win_src == SRC_FIFO);
  assign win_req  = (win_src == SRC_ALU) ? alu_req : fifo_head;
  assign win_we   = (win_src != SRC_NONE) && (win_req.rd != '0);

  wb_fifo #(
    .DEPTH (DEPTH),
    .T     (req_t)
  ) u_fifo (
    .clk       (clk),
    .rst_b     (rst_b),
    .push      (md_acc),
    .push_data (md_req),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // rd_num/rd_data only move on a real write, so they hold their last value otherwise.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_we   <= 1'b0;
      rd_num  <= '0;
      rd_data <= '0;
    end else begin
      rd_we <= win_we;
      if (win_we) begin
        rd_num  <= win_req.rd;
        rd_data <= win_req.data;
      end
    end
  end

  assign drained = fifo_empty && !rd_we;

`ifdef WB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_cnt;

  // Counts ALU wins that left a queued result waiting; any pop restarts the count.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      starve_cnt <= '0;
    end else if (fifo_pop) begin
      starve_cnt <= '0;
    end else if (!fifo_empty && alu_acc && (starve_cnt != STARVE_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  assign force_drain = !fifo_empty && (starve_cnt >= STARVE_W'(STARVE_LIMIT));
`else
  assign force_drain = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic against a queue model.
`timescale 1ns/1ps
module tb_wb_arbiter;

  localparam int XLEN         = 32;
  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;
  localparam int CNT_W        = $clog2(DEPTH + 1);

`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst_b = 1'b0;
  logic             alu_valid = 1'b0;
  logic             alu_ready;
  logic [4:0]       alu_rd = '0;
  logic [XLEN-1:0]  alu_data = '0;
  logic             md_valid = 1'b0;
  logic             md_ready;
  logic [4:0]       md_rd = '0;
  logic [XLEN-1:0]  md_data = '0;
  logic             halted = 1'b0;
  logic             rd_we;
  logic [4:0]       rd_num;
  logic [XLEN-1:0]  rd_data;
  logic [CNT_W-1:0] fifo_count;
  logic             drained;

  int check_count = 0;
  int pass_count  = 0;

  ent_t            model_q[$];
  logic            m_we;
  logic [4:0]      m_num;
  logic [XLEN-1:0] m_data;
  int              m_starve;
  logic            obs_alu_ready;
  logic            obs_md_ready;

  wb_arbiter #(
    .XLEN         (XLEN),
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .md_valid   (md_valid),
    .md_ready   (md_ready),
    .md_rd      (md_rd),
    .md_data    (md_data),
    .halted     (halted),
    .rd_we      (rd_we),
    .rd_num     (rd_num),
    .rd_data    (rd_data),
    .fifo_count (fifo_count),
    .drained    (drained)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, observed, expected);
  endtask

  task automatic modelReset();
    model_q.delete();
    m_we     = 1'b0;
    m_num    = '0;
    m_data   = '0;
    m_starve = 0;
  endtask

  // One clock: drive inputs at negedge, check readies, advance the model, check registered outputs.
  task automatic applyStimulus(input bit av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                               input bit mv, input logic [4:0] mrd, input logic [XLEN-1:0] md,
                               input bit hlt);
    bit   force_d, exp_ar, exp_mr, alu_acc, md_acc, had, popped, win_ok;
    ent_t win;
    @(negedge clk);
    alu_valid = av;  alu_rd = ard;  alu_data = ad;
    md_valid  = mv;  md_rd  = mrd;  md_data  = md;
    halted    = hlt;
    #1;
    force_d = GUARD && (m_starve >= STARVE_LIMIT) && (model_q.size() > 0);
    exp_ar  = !hlt && !force_d;
    exp_mr  = !hlt && (model_q.size() < DEPTH);
    obs_alu_ready = alu_ready;
    obs_md_ready  = md_ready;
    checkOutput("alu_ready", alu_ready, exp_ar);
    checkOutput("md_ready", md_ready, exp_mr);
    alu_acc = av && exp_ar;
    md_acc  = mv && exp_mr;
    had     = (model_q.size() > 0);
    popped  = 1'b0;
    win_ok  = 1'b0;
    win     = '0;
    if (alu_acc) begin
      win.rd = ard;  win.data = ad;  win_ok = 1'b1;
    end else if (had) begin
      win = model_q.pop_front();  win_ok = 1'b1;  popped = 1'b1;
    end
    if (md_acc) model_q.push_back({mrd, md});
    if (popped) m_starve = 0;
    else if (had && alu_acc) m_starve++;
    m_we = win_ok && (win.rd != 5'd0);
    if (m_we) begin
      m_num  = win.rd;
      m_data = win.data;
    end
    @(posedge clk);
    #1;
    checkOutput("rd_we", rd_we, m_we);
    checkOutput("rd_num", rd_num, m_num);
    checkOutput("rd_data", rd_data, m_data);
    checkOutput("fifo_count", fifo_count, model_q.size());
    checkOutput("drained", drained, (model_q.size() == 0) && !m_we);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b0);
  endtask

  // Asserts reset asynchronously mid-cycle; outputs must clear without waiting for an edge.
  task automatic applyReset();
    @(negedge clk);
    #2;
    rst_b = 1'b0;
    #1;
    checkOutput("rst_fifo_count", fifo_count, 0);
    checkOutput("rst_rd_we", rd_we, 0);
    checkOutput("rst_rd_num", rd_num, 0);
    checkOutput("rst_rd_data", rd_data, 0);
    checkOutput("rst_drained", drained, 1);
    modelReset();
    alu_valid = 1'b0;
    md_valid  = 1'b0;
    halted    = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_we", rd_we, 0);
  endtask

  initial begin
    modelReset();
    applyReset();

    $display("[TB] ALU-only write");
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, '0, 1'b0);
    checkOutput("s1_we", rd_we, 1);
    checkOutput("s1_num", rd_num, 5);
    checkOutput("s1_data", rd_data, 32'hDEADBEEF);

    $display("[TB] Simultaneous ALU and mul/div");
    applyStimulus(1'b1, 5'd3, 32'h0000_0333, 1'b1, 5'd4, 32'h0000_0444, 1'b0);
    checkOutput("s2_first_num", rd_num, 3);
    checkOutput("s2_count1", fifo_count, 1);
    idleCycle();
    checkOutput("s2_second_num", rd_num, 4);
    checkOutput("s2_second_data", rd_data, 32'h0000_0444);
    checkOutput("s2_count0", fifo_count, 0);

    $display("[TB] Three mul/div results while ALU busy");
    applyStimulus(1'b1, 5'd6, 32'h66, 1'b1, 5'd7, 32'h77, 1'b0);
    applyStimulus(1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h99, 1'b0);
    applyStimulus(1'b1, 5'd10, 32'hAA, 1'b1, 5'd11, 32'hBB, 1'b0);
    checkOutput("s3_third_md_ready", obs_md_ready, 0);
    idleCycle();
    checkOutput("s3_drain1_num", rd_num, 7);
    idleCycle();
    checkOutput("s3_drain2_num", rd_num, 9);
    checkOutput("s3_drain2_data", rd_data, 32'h99);

    $display("[TB] Write to r0");
    applyStimulus(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, '0, 1'b0);
    checkOutput("s4_alu_ready", obs_alu_ready, 1);
    checkOutput("s4_we", rd_we, 0);
    checkOutput("s4_num_hold", rd_num, 9);

    $display("[TB] Starvation behaviour");
    applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 5'(16 + i), 32'(i), 1'b0, 5'd0, '0, 1'b0);
    end
`ifdef WB_STARVE_GUARD_EN
    checkOutput("s5_alu_ready_5th", obs_alu_ready, 0);
    checkOutput("s5_fifo_written", rd_num, 2);
    checkOutput("s5_count", fifo_count, 0);
`else
    checkOutput("s5_alu_ready_5th", obs_alu_ready, 1);
    checkOutput("s5_alu_num", rd_num, 21);
    checkOutput("s5_count", fifo_count, 1);
`endif
    idleCycle();

    $display("[TB] Halt drain");
    applyStimulus(1'b1, 5'd13, 32'hD13, 1'b1, 5'd14, 32'hE14, 1'b0);
    applyStimulus(1'b1, 5'd15, 32'hF15, 1'b1, 5'd16, 32'h116, 1'b0);
    checkOutput("s6_count2", fifo_count, 2);
    applyStimulus(1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h21, 1'b1);
    checkOutput("s6_alu_blocked", obs_alu_ready, 0);
    checkOutput("s6_md_blocked", obs_md_ready, 0);
    checkOutput("s6_write1", rd_num, 14);
    applyStimulus(1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h21, 1'b1);
    checkOutput("s6_write2", rd_num, 16);
    checkOutput("s6_not_drained", drained, 0);
    applyStimulus(1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h21, 1'b1);
    checkOutput("s6_drained", drained, 1);

    $display("[TB] Reset mid-drain");
    applyStimulus(1'b1, 5'd22, 32'h22, 1'b1, 5'd23, 32'h23, 1'b0);
    applyStimulus(1'b1, 5'd24, 32'h24, 1'b1, 5'd25, 32'h25, 1'b0);
    applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 1'b1);
    checkOutput("s6_mid_count", fifo_count, 1);
    applyReset();

    $display("[TB] Randomized traffic");
    for (int i = 0; i < 400; i++) begin
      int alu_pct;
      alu_pct = (i < 200) ? 75 : 25;
      if (i == 250) applyReset();
      applyStimulus($urandom_range(0, 99) < alu_pct, 5'($urandom_range(0, 31)), $urandom,
                    $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
                    $urandom_range(0, 9) == 0);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
